// File: rtl/rx_block_assembler.sv
// rx_block_assembler: packs 32-bit AHB read words into 128-bit blocks, with
// the first word in the MSW. Finished blocks go into a small FIFO that feeds
// the AES datapath through a valid/ready handshake.
//   clk, rst              clock and synchronous active-high reset
//   clear                 synchronous flush of everything except block_count
//   word_in/valid/last    word input; word_ready is word-side backpressure
//   block_out/valid/last  FIFO head; block_ready pops it
//   level                 FIFO occupancy
//   block_count           blocks pushed since reset (wraps)
//   pad_err               sticky: a message ended on a partial block
module rx_block_assembler #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned LVL_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [31:0]        word_in,
  input  logic               word_valid,
  input  logic               word_last,
  output logic               word_ready,
  output logic [127:0]       block_out,
  output logic               block_valid,
  output logic               block_last,
  input  logic               block_ready,
  output logic [LVL_W-1:0]   level,
  output logic [CNT_W-1:0]   block_count,
  output logic               pad_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_e;

  slot_e              slot_q, slot_d;
  logic [127:0]       asm_q, asm_d;
  logic [128:0]       mem_q [DEPTH];
  logic [128:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pad_err_q, pad_err_d;

  logic               accept;
  logic               push;
  logic               pop;
  logic [127:0]       blk;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends only on registered state, so nothing combinational from block_ready.
  assign word_ready  = !rst && !clear && (level_q != LVL_W'(DEPTH));
  assign block_valid = (level_q != '0);
  assign block_out   = mem_q[rd_ptr_q][127:0];
  assign block_last  = mem_q[rd_ptr_q][128];
  assign level       = level_q;
  assign block_count = cnt_q;
  assign pad_err     = pad_err_q;

  assign accept = word_valid && word_ready;
  assign push   = accept && ((slot_q == SLOT3) || word_last);
  assign pop    = block_valid && block_ready;

  always_comb begin
    blk = asm_q;
    unique case (slot_q)
      SLOT0: blk[127:96] = word_in;
      SLOT1: blk[95:64]  = word_in;
      SLOT2: blk[63:32]  = word_in;
      SLOT3: blk[31:0]   = word_in;
    endcase
  end

  always_comb begin
    slot_d    = slot_q;
    asm_d     = asm_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    pad_err_d = pad_err_q;

    if (clear) begin
      slot_d    = SLOT0;
      asm_d     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      pad_err_d = 1'b0;
    end else begin
      if (accept) begin
        if (push) begin
          mem_d[wr_ptr_q] = {word_last, blk};
          wr_ptr_d        = ptr_inc(wr_ptr_q);
          asm_d           = '0;
          slot_d          = SLOT0;
          cnt_d           = cnt_q + CNT_W'(1);
          if (word_last && (slot_q != SLOT3)) pad_err_d = 1'b1;
        end else begin
          asm_d  = blk;
          slot_d = slot_e'(slot_q + 2'd1);
        end
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= SLOT0;
      asm_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      pad_err_q <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      asm_q     <= asm_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      pad_err_q <= pad_err_d;
    end
  end

endmodule

// File: tb/tb_rx_block_assembler.sv
module tb_rx_block_assembler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic [31:0]  word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_last = 1'b0;
  logic         block_ready = 1'b0;
  logic         word_ready, word_ready4;
  logic [127:0] block_out, block_out4;
  logic         block_valid, block_valid4;
  logic         block_last, block_last4;
  logic [1:0]   level, level4;
  logic [15:0]  block_count;
  logic [3:0]   block_count4;
  logic         pad_err, pad_err4;

  always #5 clk = ~clk;

  rx_block_assembler dut (
    .clk(clk), .rst(rst), .clear(clear),
    .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
    .word_ready(word_ready),
    .block_out(block_out), .block_valid(block_valid), .block_last(block_last),
    .block_ready(block_ready),
    .level(level), .block_count(block_count), .pad_err(pad_err)
  );

  rx_block_assembler #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear),
    .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
    .word_ready(word_ready4),
    .block_out(block_out4), .block_valid(block_valid4), .block_last(block_last4),
    .block_ready(block_ready),
    .level(level4), .block_count(block_count4), .pad_err(pad_err4)
  );

  int           total = 0;
  int           bad = 0;
  int           n_pops = 0;
  bit           mon_en = 1'b0;
  logic [128:0] sb_q[$];
  logic [1:0]   m_slot = '0;
  logic [127:0] m_asm = '0;
  logic [15:0]  exp_cnt = '0;
  logic         exp_pad = 1'b0;

  // Scoreboard/model: sampled on negedge, ahead of the edge that acts on it.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (level !== 2'(sb_q.size())) begin
        bad++; $display("FAIL level: got %0d want %0d", level, sb_q.size());
      end
      total++;
      if (block_valid !== (sb_q.size() != 0)) begin
        bad++; $display("FAIL block_valid: got %b want %b", block_valid, sb_q.size() != 0);
      end
      total++;
      if (word_ready !== (!rst && !clear && sb_q.size() != 2)) begin
        bad++; $display("FAIL word_ready: got %b want %b", word_ready,
                        !rst && !clear && sb_q.size() != 2);
      end
      total++;
      if (block_count !== exp_cnt || block_count4 !== exp_cnt[3:0]) begin
        bad++; $display("FAIL block_count: got %0d/%0d want %0d/%0d",
                        block_count, block_count4, exp_cnt, exp_cnt[3:0]);
      end
      total++;
      if (pad_err !== exp_pad) begin
        bad++; $display("FAIL pad_err: got %b want %b", pad_err, exp_pad);
      end

      if (rst) begin
        sb_q.delete(); m_slot = '0; m_asm = '0; exp_cnt = '0; exp_pad = 1'b0;
      end else if (clear) begin
        sb_q.delete(); m_slot = '0; m_asm = '0; exp_pad = 1'b0;
      end else begin
        if (block_ready && sb_q.size() != 0) begin
          total++;
          if ({block_last, block_out} !== sb_q[0]) begin
            bad++; $display("FAIL pop_data: got %h want %h", {block_last, block_out}, sb_q[0]);
          end
          void'(sb_q.pop_front());
          n_pops++;
        end
        if (word_valid && word_ready) begin
          m_asm[127 - 32 * m_slot -: 32] = word_in;
          if (m_slot == 2'd3 || word_last) begin
            sb_q.push_back({word_last, m_asm});
            if (word_last && m_slot != 2'd3) exp_pad = 1'b1;
            exp_cnt++;
            m_asm  = '0;
            m_slot = '0;
          end else begin
            m_slot++;
          end
        end
      end
    end
  end

  // Caller is just after a posedge; returns just after the accepting posedge.
  task automatic send_word(input logic [31:0] w, input logic last);
    word_in = w; word_valid = 1'b1; word_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (word_ready) begin
        @(posedge clk); #1;
        word_valid = 1'b0; word_last = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL send_timeout: got word_ready=0 for 200 cycles want 1 (word %h)", w);
    word_valid = 1'b0; word_last = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; word_valid = 1'b0; word_last = 1'b0;
    @(negedge clk);
    total++;
    if (word_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b want 0", word_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    total++;
    if (block_out !== '0 || block_valid !== 1'b0 || block_last !== 1'b0 ||
        level !== 2'd0 || block_count !== 16'd0 || pad_err !== 1'b0 || block_count4 !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: got out=%h v=%b l=%b lvl=%0d cnt=%0d pad=%b want all 0",
               block_out, block_valid, block_last, level, block_count, pad_err);
    end
  endtask

  task automatic test_single_block;
    block_ready = 1'b1;
    send_word(32'habcd52c2, 1'b0);
    send_word(32'hf9c6f303, 1'b0);
    send_word(32'h030f8303, 1'b0);
    send_word(32'h1ab61040, 1'b1);
    total++;
    if (block_valid !== 1'b1 || block_out !== 128'habcd52c2f9c6f303030f83031ab61040 ||
        block_last !== 1'b1) begin
      bad++; $display("FAIL single_block: got v=%b out=%h last=%b want 1 abcd52c2f9c6f303030f83031ab61040 1",
                      block_valid, block_out, block_last);
    end
    total++;
    if (block_count !== 16'd1 || pad_err !== 1'b0) begin
      bad++; $display("FAIL single_cnt: got cnt=%0d pad=%b want 1 0", block_count, pad_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int p0;
    block_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_word(32'(i), 1'b0);
    @(negedge clk);
    total++;
    if (word_ready !== 1'b0 || level !== 2'd2) begin
      bad++; $display("FAIL bp_full: got ready=%b level=%0d want 0 2", word_ready, level);
    end
    @(posedge clk); #1;
    p0 = n_pops;
    fork
      begin
        for (int i = 9; i <= 12; i++) send_word(32'(i), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (block_out !== 128'h00000001000000020000000300000004) begin
          bad++; $display("FAIL bp_head: got %h want 00000001000000020000000300000004", block_out);
        end
        block_ready = 1'b1;
      end
    join
    for (int i = 0; i < 20 && level !== 2'd0; i++) @(posedge clk);
    #1;
    total++;
    if (n_pops - p0 !== 3 || level !== 2'd0) begin
      bad++; $display("FAIL bp_drain: got pops=%0d level=%0d want 3 0", n_pops - p0, level);
    end
  endtask

  task automatic test_partial;
    block_ready = 1'b0;
    send_word(32'hdeadbeef, 1'b0);
    send_word(32'hcafef00d, 1'b1);
    total++;
    if (block_out !== 128'hdeadbeefcafef00d0000000000000000 || block_last !== 1'b1 || pad_err !== 1'b1) begin
      bad++; $display("FAIL partial: got out=%h last=%b pad=%b want deadbeefcafef00d0000000000000000 1 1",
                      block_out, block_last, pad_err);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (pad_err !== 1'b1) begin
      bad++; $display("FAIL pad_sticky: got %b want 1", pad_err);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    total++;
    if (pad_err !== 1'b0 || level !== 2'd0 || block_valid !== 1'b0 || block_count !== 16'd5) begin
      bad++; $display("FAIL clear: got pad=%b level=%0d v=%b cnt=%0d want 0 0 0 5",
                      pad_err, level, block_valid, block_count);
    end
  endtask

  task automatic test_push_pop;
    block_ready = 1'b0;
    send_word(32'h10000001, 1'b0);
    send_word(32'h10000002, 1'b0);
    send_word(32'h10000003, 1'b0);
    send_word(32'h10000004, 1'b0);
    send_word(32'h20000001, 1'b0);
    send_word(32'h20000002, 1'b0);
    send_word(32'h20000003, 1'b0);
    block_ready = 1'b1;
    send_word(32'h20000004, 1'b1);
    total++;
    if (level !== 2'd1 || block_out !== 128'h20000001200000022000000320000004 || block_last !== 1'b1) begin
      bad++; $display("FAIL push_pop: got level=%0d out=%h last=%b want 1 20000001200000022000000320000004 1",
                      level, block_out, block_last);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_block;
    block_ready = 1'b1;
    send_word(32'haaaaaaaa, 1'b0);
    send_word(32'hbbbbbbbb, 1'b0);
    test_reset();
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    send_word(32'h44444444, 1'b1);
    total++;
    if (block_out !== 128'h11111111222222223333333344444444 || block_count !== 16'd1) begin
      bad++; $display("FAIL reset_mid: got out=%h cnt=%0d want 11111111222222223333333344444444 1",
                      block_out, block_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_count_wrap;
    test_reset();
    block_ready = 1'b1;
    for (int b = 0; b < 17; b++)
      for (int j = 0; j < 4; j++) send_word($urandom, j == 3);
    total++;
    if (block_count4 !== 4'd1 || block_count !== 16'd17) begin
      bad++; $display("FAIL count_wrap: got %0d/%0d want 1/17", block_count4, block_count);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_partial();
    test_push_pop();
    test_reset_mid_block();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
